// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises uart_rxd, finds start edges and samples each bit at its centre.
// states: IDLE wait for fall | START verify mid-start | DATA shift payload | STOP check stop bit
module uart_rx #(
  parameter int BIT_RATE     = 9600,
  parameter int PAYLOAD_BITS = 8,
  parameter int CLK_HZ       = 20_000_000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    uart_rxd,
  input  logic                    uart_rx_en,
  output logic                    uart_rx_busy,
  output logic                    uart_rx_valid,
  output logic [PAYLOAD_BITS-1:0] uart_rx_data,
  output logic                    uart_rx_frame_err
);

  localparam int CPB  = CLK_HZ / BIT_RATE;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB + 1);
  localparam int IW   = (PAYLOAD_BITS > 1) ? $clog2(PAYLOAD_BITS) : 1;

  localparam logic [CW-1:0] HALF_M1  = CW'(HALF - 1);
  localparam logic [CW-1:0] CPB_M1   = CW'(CPB - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(PAYLOAD_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic                    r_rxd_s1;
  logic                    r_rxd_s;
  logic                    r_rxd_d;
  logic [CW-1:0]           r_cyc;
  logic [IW-1:0]           r_idx;
  logic [PAYLOAD_BITS-1:0] r_shift;
  logic                    r_valid;
  logic                    r_ferr;
  logic [PAYLOAD_BITS-1:0] r_data;

  logic w_fall;
  logic w_shift_en;
  logic w_restart;
  logic w_load;
  logic w_ferr;

  assign w_fall = r_rxd_d & ~r_rxd_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rxd_s1 <= 1'b1;
      r_rxd_s  <= 1'b1;
      r_rxd_d  <= 1'b1;
    end else begin
      r_rxd_s1 <= uart_rxd;
      r_rxd_s  <= r_rxd_s1;
      r_rxd_d  <= r_rxd_s;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_shift_en = 1'b0;
    w_restart  = 1'b0;
    w_load     = 1'b0;
    w_ferr     = 1'b0;
    if (!uart_rx_en) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_fall) w_next = S_START;
        end
        S_START: begin
          if (r_cyc == HALF_M1) w_next = r_rxd_s ? S_IDLE : S_DATA;
        end
        S_DATA: begin
          if (r_cyc == CPB_M1) begin
            w_shift_en = 1'b1;
            w_restart  = 1'b1;
            if (r_idx == LAST_IDX) w_next = S_STOP;
          end
        end
        S_STOP: begin
          if (r_cyc == CPB_M1) begin
            w_next = S_IDLE;
            if (r_rxd_s) w_load = 1'b1;
            else         w_ferr = 1'b1;
          end
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  // Counter and index clear on every state change, so each state times from its own entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cyc   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_data  <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) begin
        r_cyc <= '0;
        r_idx <= '0;
      end else if (w_restart) begin
        r_cyc <= '0;
        r_idx <= r_idx + 1'b1;
      end else if (r_state != S_IDLE) begin
        r_cyc <= r_cyc + 1'b1;
      end
      if (w_shift_en) r_shift[r_idx] <= r_rxd_s;
      r_valid <= w_load;
      r_ferr  <= w_ferr;
      if (w_load) r_data <= r_shift;
    end
  end

  assign uart_rx_busy      = (r_state != S_IDLE);
  assign uart_rx_valid     = r_valid;
  assign uart_rx_frame_err = r_ferr;
  assign uart_rx_data      = r_data;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are driven serially, expected pulses queued and matched on output.
module tb_uart_rx;

  localparam int BIT_RATE = 100_000;
  localparam int CLK_HZ   = 2_300_000;
  localparam int CPB      = 23;
  localparam int HALF     = 11;
  localparam int LAT      = 2 + HALF + 9 * CPB;

  logic       clk;
  logic       rst_n;
  logic       uart_rxd;
  logic       uart_rx_en;
  logic       uart_rx_busy;
  logic       uart_rx_valid;
  logic [7:0] uart_rx_data;
  logic       uart_rx_frame_err;

  uart_rx #(
    .BIT_RATE    (BIT_RATE),
    .PAYLOAD_BITS(8),
    .CLK_HZ      (CLK_HZ)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .uart_rxd         (uart_rxd),
    .uart_rx_en       (uart_rx_en),
    .uart_rx_busy     (uart_rx_busy),
    .uart_rx_valid    (uart_rx_valid),
    .uart_rx_data     (uart_rx_data),
    .uart_rx_frame_err(uart_rx_frame_err)
  );

  typedef struct {
    bit         err;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t       sb_q[$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         cnt = 0;
  logic [7:0] last_good = 8'h00;
  bit         prev_pulse = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cnt <= cnt + 1;

  task automatic check_eq(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, act, exp, cnt);
    end
  endtask

  task automatic wait_cnt(input int target);
    while (cnt < target) @(negedge clk);
  endtask

  // Called on a negedge; the following posedge is where the first sync flop sees the start bit.
  task automatic send_frame(input logic [7:0] d, input logic stop, input bit track);
    exp_t e;
    if (track) begin
      e.cyc = cnt + 1 + LAT;
      e.err = !stop;
      if (stop) last_good = d;
      e.data = last_good;
      sb_q.push_back(e);
    end
    uart_rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = d[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rxd = stop;
    repeat (CPB) @(negedge clk);
    uart_rxd = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (uart_rx_valid || uart_rx_frame_err) begin
        check_eq("one_cycle", int'(prev_pulse), 0);
        check_eq("busy_at_pulse", int'(uart_rx_busy), 0);
        check_eq("sb_nonempty", int'(sb_q.size() != 0), 1);
        if (sb_q.size() != 0) begin
          exp_t e;
          e = sb_q.pop_front();
          check_eq("kind", int'({uart_rx_valid, uart_rx_frame_err}), e.err ? 1 : 2);
          check_eq("data", int'(uart_rx_data), int'(e.data));
          check_eq("when", cnt, e.cyc);
        end
      end
      prev_pulse <= uart_rx_valid || uart_rx_frame_err;
    end else begin
      prev_pulse <= 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    rst_n      = 1'b0;
    uart_rxd   = 1'b1;
    uart_rx_en = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", int'(uart_rx_busy), 0);
    check_eq("rst_valid", int'(uart_rx_valid), 0);
    check_eq("rst_ferr", int'(uart_rx_frame_err), 0);
    check_eq("rst_data", int'(uart_rx_data), 0);
    rst_n      = 1'b1;
    uart_rx_en = 1'b1;
    repeat (5) @(negedge clk);

    // single frame with busy window
    n0 = cnt;
    fork
      send_frame(8'h55, 1'b1, 1'b1);
      begin
        wait_cnt(n0 + 2);
        check_eq("busy_before_e2", int'(uart_rx_busy), 0);
        wait_cnt(n0 + 3);
        check_eq("busy_after_e2", int'(uart_rx_busy), 1);
        wait_cnt(n0 + LAT);
        check_eq("busy_before_pulse", int'(uart_rx_busy), 1);
      end
    join
    repeat (10) @(negedge clk);

    // back-to-back
    send_frame(8'hA3, 1'b1, 1'b1);
    send_frame(8'h00, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b1);
    repeat (10) @(negedge clk);

    // false start glitch
    n0 = cnt;
    uart_rxd = 1'b0;
    repeat (5) @(negedge clk);
    uart_rxd = 1'b1;
    wait_cnt(n0 + 3);
    check_eq("glitch_busy", int'(uart_rx_busy), 1);
    wait_cnt(n0 + 2 + HALF);
    check_eq("glitch_busy_end", int'(uart_rx_busy), 1);
    wait_cnt(n0 + 3 + HALF);
    check_eq("glitch_idle", int'(uart_rx_busy), 0);
    repeat (CPB) @(negedge clk);

    // break after 0x3C: one frame error, then no retrigger while low
    send_frame(8'h3C, 1'b1, 1'b1);
    begin
      exp_t e;
      e.cyc = cnt + 1 + LAT;
      e.err = 1'b1;
      e.data = last_good;
      sb_q.push_back(e);
    end
    uart_rxd = 1'b0;
    repeat (30 * CPB) @(negedge clk);
    check_eq("break_idle", int'(uart_rx_busy), 0);
    check_eq("break_data", int'(uart_rx_data), 8'h3C);
    uart_rxd = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    send_frame(8'h5A, 1'b1, 1'b1);
    repeat (10) @(negedge clk);

    // stop bit forced low
    send_frame(8'h81, 1'b0, 1'b1);
    repeat (2 * CPB) @(negedge clk);
    check_eq("stop0_data_kept", int'(uart_rx_data), 8'h5A);

    // reset during data bit 4
    n0 = cnt;
    fork
      send_frame(8'hC7, 1'b1, 1'b0);
      begin
        wait_cnt(n0 + 5 * CPB + CPB / 2);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_busy", int'(uart_rx_busy), 0);
        check_eq("mid_rst_valid", int'(uart_rx_valid), 0);
        check_eq("mid_rst_ferr", int'(uart_rx_frame_err), 0);
        check_eq("mid_rst_data", int'(uart_rx_data), 0);
      end
    join
    last_good = 8'h00;
    rst_n = 1'b1;
    repeat (CPB) @(negedge clk);
    send_frame(8'h12, 1'b1, 1'b1);
    repeat (10) @(negedge clk);

    // enable dropped during bit 2
    n0 = cnt;
    fork
      send_frame(8'h99, 1'b1, 1'b0);
      begin
        wait_cnt(n0 + 3 * CPB + CPB / 2);
        check_eq("en_busy_before", int'(uart_rx_busy), 1);
        uart_rx_en = 1'b0;
        @(negedge clk);
        check_eq("en_busy_after", int'(uart_rx_busy), 0);
      end
    join
    repeat (CPB) @(negedge clk);
    uart_rx_en = 1'b1;
    repeat (CPB) @(negedge clk);
    send_frame(8'h66, 1'b1, 1'b1);
    repeat (2 * CPB) @(negedge clk);

    check_eq("sb_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
